mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit implementing the M-extension ops MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Datapath width is parametrised by XLEN.
- Sits beside the EX-stage ALU; the pipeline stalls on a valid/ready request handshake and collects the result through a valid/ready response handshake.
- Supports flush for squashed instructions.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8
- TAG_W, 5, width of destination-register tag carried with the op

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort in-flight op, no response produced
- req_valid  in  1  request present
- req_ready  out  1  unit can accept request
- req_funct3  in  3  op select, M-extension funct3 encoding
- req_rs1  in  XLEN  multiplicand / dividend
- req_rs2  in  XLEN  multiplier / divisor
- req_tag  in  TAG_W  destination register tag
- resp_valid  out  1  result present
- resp_ready  in  1  consumer takes result
- resp_data  out  XLEN  result
- resp_tag  out  TAG_W  tag of the op that produced resp_data
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - resp_valid = 0, resp_data = 0, resp_tag = 0, busy = 0.
  - req_ready = 0 while rst is high; req_ready = 1 in the first cycle after rst falls.
- FSM states: IDLE, CALC, FIX, DONE.
- Acceptance:
  - req_ready = (state == IDLE) && !flush.
  - Accept on req_valid && req_ready.
  - On accept, latch funct3 and tag, form operand magnitudes, and record result sign.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- IDLE -> CALC: on accept; iteration counter = 0.
- CALC: one radix-2 step per cycle for exactly XLEN cycles, then go to FIX.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract, producing quotient and remainder magnitudes.
- FIX: one cycle.
  - Multiply: negate the product if the sign is negative.
  - Quotient: negate if signed op and operand signs differ.
  - Remainder: takes the dividend's sign.
  - Result selection: MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - Register resp_data and resp_tag, then go to DONE.
- DONE:
  - resp_valid = 1; resp_data and resp_tag are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE. No request is accepted in that same cycle.
- Latency: resp_valid rises exactly XLEN+2 cycles after the accept edge (34 for XLEN=32).
- Special cases (results always spec-correct):
  - Divide by zero: quotient = all ones; remainder = dividend (signed and unsigned).
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
  - Without the optional feature, special cases run the full latency, and FIX substitutes the result.
- Flush:
  - Any state returns to IDLE at the next edge; resp_valid drops and no response is produced.
  - Flush in the same cycle as req_valid: the request is not accepted.
  - Flush in DONE concurrent with resp_ready: the response is counted as not delivered.
- Reset mid-op behaves as flush and also clears the output registers.
- Undefined funct3 cannot occur, because the decoder only issues the eight M ops.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: on accept, divide-by-zero, signed overflow, and any multiply with a zero operand bypass CALC/FIX and go IDLE -> DONE. resp_valid rises 1 cycle after the accept edge.
- Undefined: all ops take XLEN+2 cycles. Results are identical in both builds.

Decomposition:
- Shared defines package:
  - mdu_state_t enum (IDLE, CALC, FIX, DONE).
  - Reuse of the existing MUL..REMU funct3 constants and the M_INSTR funct7 constant.
  - Helper function is_signed_rs1 / is_signed_rs2 keyed on funct3.
- One sub-module, mdu_step: combinational single radix-2 iteration. It takes the accumulator/remainder, operand and mode, and returns the next accumulator plus the quotient bit.

Test Plan (XLEN=32):
- MUL rs1=7, rs2=0xFFFFFFFD -> resp_data 0xFFFFFFEB, resp_valid exactly 34 cycles after accept, resp_tag echoed.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5,0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Latency is 34 cycles without MDU_EARLY_OUT_EN and 1 cycle with it.
- Backpressure: hold resp_ready low 5 cycles in DONE -> resp_data and resp_tag stable, req_ready 0; after the handshake, req_ready is 1 on the next cycle.
- Flush asserted on cycle 10 of CALC -> no resp_valid ever; req_ready 1 on the next cycle; a new MUL 3x4 then returns 12.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// mdu_iter shared definitions: FSM states, M-extension encodings,
// and operand signedness helpers keyed on funct3.
`timescale 1ns/1ps
package mdu_iter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

    localparam logic [6:0] M_INSTR   = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_m_op(logic [6:0] funct7);
        return funct7 == M_INSTR;
    endfunction

    function automatic logic is_signed_rs1(logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic is_signed_rs2(logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter request/response handshake bundle.
// master = pipeline side, slave = the multiply/divide unit.
`timescale 1ns/1ps
interface mdu_iter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// For divide, the quotient bit is returned separately (acc_next lsb is 0).
`timescale 1ns/1ps
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // multiply: {hi,lo} holds partial product above the remaining multiplier
    // divide: {rem,quo} shifts left, quotient bits enter at the bottom
    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opnd};
        q_bit  = ~diff[XLEN];
        if (is_div) begin
            acc_next = {(q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                        acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit (XLEN+2 cycle latency).
// Optional MDU_EARLY_OUT_EN: trivial ops skip CALC/FIX and respond next cycle.
`timescale 1ns/1ps
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    mdu_iter_if.slave bus,
    output logic      busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   opnd_q, rs1_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q, s1_q, dz_q, ovf_q;
    logic [XLEN-1:0]   resp_data_q;
    logic [TAG_W-1:0]  resp_tag_q;

    logic              accept, early_in;
    logic              s1_in, s2_in, dz_in, ovf_in;
    logic [XLEN-1:0]   mag1_in, mag2_in;
    logic [2*XLEN-1:0] step_acc;
    logic              step_q;

    logic              fx_idle, fx_neg, fx_s1, fx_dz, fx_ovf;
    logic [2:0]        fx_f3;
    logic [XLEN-1:0]   fx_rs1, quo, rem, res;
    logic [2*XLEN-1:0] fx_acc, prod;

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div   (f3_q[2]),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // request decode: operand magnitudes, signs and special cases
    always_comb begin
        s1_in   = is_signed_rs1(bus.req_funct3) & bus.req_rs1[XLEN-1];
        s2_in   = is_signed_rs2(bus.req_funct3) & bus.req_rs2[XLEN-1];
        mag1_in = s1_in ? -bus.req_rs1 : bus.req_rs1;
        mag2_in = s2_in ? -bus.req_rs2 : bus.req_rs2;
        dz_in   = bus.req_rs2 == '0;
        ovf_in  = (bus.req_funct3 == F3_DIV || bus.req_funct3 == F3_REM)
                  && bus.req_rs1 == MIN_NEG && (&bus.req_rs2);
`ifdef MDU_EARLY_OUT_EN
        early_in = bus.req_funct3[2] ? (dz_in || ovf_in)
                                     : (bus.req_rs1 == '0 || dz_in);
`else
        early_in = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and handshake outputs
    always_comb begin
        bus.req_ready  = (state_q == IDLE) && !flush && !rst;
        accept         = bus.req_valid && bus.req_ready;
        bus.resp_valid = state_q == DONE;
        busy           = state_q != IDLE;
        state_d        = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = early_in ? DONE : CALC;
            CALC: if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // sign fix-up and result select; in IDLE it serves the early-out path
    always_comb begin
        fx_idle = state_q == IDLE;
        fx_f3   = fx_idle ? bus.req_funct3 : f3_q;
        fx_acc  = fx_idle ? '0 : acc_q;
        fx_neg  = fx_idle ? (s1_in ^ s2_in) : neg_q;
        fx_s1   = fx_idle ? s1_in : s1_q;
        fx_dz   = fx_idle ? dz_in : dz_q;
        fx_ovf  = fx_idle ? ovf_in : ovf_q;
        fx_rs1  = fx_idle ? bus.req_rs1 : rs1_q;
        prod    = fx_neg ? -fx_acc : fx_acc;
        quo     = fx_neg ? -fx_acc[XLEN-1:0] : fx_acc[XLEN-1:0];
        rem     = fx_s1 ? -fx_acc[2*XLEN-1:XLEN] : fx_acc[2*XLEN-1:XLEN];
        if (fx_dz) begin
            quo = '1;
            rem = fx_rs1;
        end else if (fx_ovf) begin
            quo = fx_rs1;
            rem = '0;
        end
        unique case (fx_f3)
            F3_MUL:                       res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              res = quo;
            default:                      res = rem;
        endcase
    end

    // operand capture, iteration and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            if (accept) begin
                f3_q   <= bus.req_funct3;
                tag_q  <= bus.req_tag;
                rs1_q  <= bus.req_rs1;
                neg_q  <= s1_in ^ s2_in;
                s1_q   <= s1_in;
                dz_q   <= dz_in;
                ovf_q  <= ovf_in;
                cnt_q  <= '0;
                acc_q  <= {{XLEN{1'b0}},
                           bus.req_funct3[2] ? mag1_in : mag2_in};
                opnd_q <= bus.req_funct3[2] ? mag2_in : mag1_in;
                if (early_in) begin
                    resp_data_q <= res;
                    resp_tag_q  <= bus.req_tag;
                end
            end
            if (state_q == CALC) begin
                acc_q <= step_acc
                         | {{(2*XLEN-1){1'b0}}, step_q & f3_q[2]};
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == FIX && !flush) begin
                resp_data_q <= res;
                resp_tag_q  <= tag_q;
            end
        end
    end

    assign bus.resp_data = resp_data_q;
    assign bus.resp_tag  = resp_tag_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32): directed vectors,
// special cases, backpressure, flush, reset and randomized ops.
`timescale 1ns/1ps
module tb_mdu_iter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_fail = 0;

    mdu_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mdu_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // reference: plain wide arithmetic plus the M-extension special rules
    function automatic logic [31:0] ref_result(logic [2:0] f3,
                                               logic [31:0] a, logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(logic [2:0] f3,
                                       logic [31:0] a, logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if (f3[2] && b == 0) return 1;
        if (f3 == 3'd4 || f3 == 3'd6)
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!f3[2] && (a == 0 || b == 0)) return 1;
`endif
        return XLEN + 2;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         output logic ok);
        int n;
        @(negedge clk);
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_tag    = tag;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // cycles counted from the accept edge to the edge that sees resp_valid
    task automatic wait_resp(output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 200) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = n + 1;
                break;
            end
            @(posedge clk);
            n++;
        end
    endtask

    task automatic take_resp(output logic [31:0] d, output logic [4:0] t);
        d = bus.resp_data;
        t = bus.resp_tag;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, busy} !== 3'b000
            || bus.resp_data !== 32'h0 || bus.resp_tag !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/busy=%b data=%h tag=%h req 000/0/0",
                     {bus.req_ready, bus.resp_valid, busy},
                     bus.resp_data, bus.resp_tag);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b req 1", bus.req_ready);
        end
    endtask

    task automatic run_table(input string name, input int n,
                             input logic [2:0] f3s[16],
                             input logic [31:0] as[16], input logic [31:0] bs[16],
                             input logic [31:0] exps[16]);
        logic ok;
        int lat;
        logic [31:0] d;
        logic [4:0] t;
        for (int i = 0; i < n; i++) begin
            issue(f3s[i], as[i], bs[i], 5'(i + 3), ok);
            wait_resp(lat);
            d = 'x;
            t = 'x;
            if (lat > 0) take_resp(d, t);
            n_checks++;
            if (d !== exps[i] || t !== 5'(i + 3)) begin
                n_fail++;
                $display("FAIL %s[%0d] data/tag: got %h/%h req %h/%h",
                         name, i, d, t, exps[i], 5'(i + 3));
            end
            n_checks++;
            if (lat !== ref_latency(f3s[i], as[i], bs[i])) begin
                n_fail++;
                $display("FAIL %s[%0d] latency: got %0d req %0d", name, i, lat,
                         ref_latency(f3s[i], as[i], bs[i]));
            end
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f3s[16];
        logic [31:0] as[16], bs[16], ex[16];
        f3s = '{0, 1, 3, 2, 4, 6, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        as  = '{7, 32'h8000_0000, '1, '1, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                32'hFFFF_FFF9, 32'hFFFF_FFF9, 0, 0, 0, 0, 0, 0, 0, 0};
        bs  = '{32'hFFFF_FFFD, 32'h8000_0000, '1, '1, 2, 2, 2, 2,
                0, 0, 0, 0, 0, 0, 0, 0};
        ex  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1,
                0, 0, 0, 0, 0, 0, 0, 0};
        run_table("directed", 8, f3s, as, bs, ex);
    endtask

    task automatic test_special();
        logic [2:0]  f3s[16];
        logic [31:0] as[16], bs[16], ex[16];
        f3s = '{4, 6, 4, 6, 5, 7, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        as  = '{5, 5, 32'h8000_0000, 32'h8000_0000, 5, 5, 0, 32'h1234,
                0, 0, 0, 0, 0, 0, 0, 0};
        bs  = '{0, 0, '1, '1, 0, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ex  = '{'1, 5, 32'h8000_0000, 0, '1, 5, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0};
        run_table("special", 8, f3s, as, bs, ex);
    endtask

    task automatic test_back_to_back_backpressure();
        logic ok;
        int lat;
        logic [31:0] d;
        logic [4:0] t;
        issue(3'd5, 32'd1000, 32'd7, 5'd21, ok);
        wait_resp(lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd142
                || bus.resp_tag !== 5'd21 || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: vld=%b data=%h tag=%h rdy=%b req 1/%h/%h/0",
                         i, bus.resp_valid, bus.resp_data, bus.resp_tag,
                         bus.req_ready, 32'd142, 5'd21);
            end
            @(negedge clk);
        end
        take_resp(d, t);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: rdy=%b vld=%b req 1/0",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_flush();
        logic ok;
        int lat, seen;
        logic [31:0] d;
        logic [4:0] t;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_rs1 = 32'd9;
        bus.req_rs2 = 32'd9;
        flush = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_with_req ready: got %b req 0", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_with_req busy: got %b req 0", busy);
        end
        issue(3'd0, 32'd3, 32'd5, 5'd9, ok);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc: rdy=%b busy=%b req 1/0", bus.req_ready, busy);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_no_resp: got %0d valid cycles req 0", seen);
        end
        issue(3'd0, 32'd3, 32'd4, 5'd17, ok);
        wait_resp(lat);
        d = 'x;
        t = 'x;
        if (lat > 0) take_resp(d, t);
        n_checks++;
        if (d !== 32'd12 || t !== 5'd17) begin
            n_fail++;
            $display("FAIL flush_then_mul: got %h/%h req %h/%h", d, t, 32'd12, 5'd17);
        end
    endtask

    task automatic test_reset_midop();
        logic ok;
        issue(3'd0, 32'd3, 32'd5, 5'd2, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_tag !== 5'h0
            || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: busy=%b data=%h tag=%h rdy=%b req 0/0/0/0",
                     busy, bus.resp_data, bus.resp_tag, bus.req_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midop_ready: got %b req 1", bus.req_ready);
        end
    endtask

    task automatic test_random();
        logic ok;
        int lat;
        logic [2:0] f3;
        logic [31:0] a, b, d, exp_d;
        logic [4:0] tag, t;
        for (int i = 0; i < 150; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            tag = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: a = 0;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            exp_d = ref_result(f3, a, b);
            issue(f3, a, b, tag, ok);
            wait_resp(lat);
            d = 'x;
            t = 'x;
            if (lat > 0) take_resp(d, t);
            n_checks++;
            if (d !== exp_d || t !== tag || lat !== ref_latency(f3, a, b)) begin
                n_fail++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h: got %h/%h lat %0d req %h/%h lat %0d",
                         i, f3, a, b, d, t, lat, exp_d, tag, ref_latency(f3, a, b));
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_directed();
        test_special();
        test_back_to_back_backpressure();
        test_flush();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
